// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, transmit FSM state encoding and frame builder
// used by the key sender and its byte FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    GAP  = 2'd3
  } ps2_state_e;

  // Bit 0 is the first bit on the wire: start, data LSB first, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO: writes 0..WR_MAX bytes per cycle (byte 0 first),
// reads one byte per cycle, read data shows the head entry combinationally.
module ps2_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int WR_MAX = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(WR_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NW-1:0]         wr_n,
  input  logic [8*WR_MAX-1:0]   wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign empty   = (count == '0);
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // The writer guarantees room, so count never exceeds DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(wr_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_MAX; i++) begin
      if (NW'(i) < wr_n) mem[wr_ptr + AW'(i)] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ps2_key_sender.sv
// Device-side PS/2 keyboard emulator: key events -> scan-code bytes -> PS/2 frames.
// Define PS2_TX_EXT_EN to honour key_ext and emit the 0xE0 prefix.
module ps2_key_sender
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_ext,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

`ifdef PS2_TX_EXT_EN
  localparam int MAX_BYTES = 3;
`else
  localparam int MAX_BYTES = 2;
`endif
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int UW      = CW + 1;
  localparam int NW      = $clog2(MAX_BYTES + 1);
  localparam int GAP_CYC = 2 * CLK_DIV * GAP_BITS;
  localparam int DIV_W   = $clog2(GAP_CYC);

  localparam logic [DIV_W-1:0] HALF_LD  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LD   = DIV_W'(GAP_CYC - 1);
  localparam logic [3:0]       LAST_IDX = 4'(PS2_FRAME_BITS - 1);

  // Event expansion: bytes packed with the first byte on the wire in [7:0].
  logic [NW-1:0]          evt_n;
  logic [8*MAX_BYTES-1:0] evt_data;

  always_comb begin
    evt_n    = '0;
    evt_data = '0;
`ifdef PS2_TX_EXT_EN
    case ({key_ext, key_release})
      2'b00: begin evt_n = NW'(1); evt_data[7:0]  = key_code; end
      2'b01: begin evt_n = NW'(2); evt_data[15:0] = {key_code, PS2_BREAK}; end
      2'b10: begin evt_n = NW'(2); evt_data[15:0] = {key_code, PS2_EXT}; end
      default: begin evt_n = NW'(3); evt_data = {key_code, PS2_BREAK, PS2_EXT}; end
    endcase
`else
    if (key_release) begin
      evt_n         = NW'(2);
      evt_data      = {key_code, PS2_BREAK};
    end else begin
      evt_n         = NW'(1);
      evt_data[7:0] = key_code;
    end
`endif
  end

`ifndef PS2_TX_EXT_EN
  logic unused_key_ext;
  assign unused_key_ext = key_ext;
`endif

  // Handshake: an event transfers on a posedge with key_valid && key_ready
  // (rst has priority); key_ready never depends on key_valid, and the whole
  // event is staged for one cycle before all its bytes enter the FIFO together.
  logic                   stg_valid;
  logic [NW-1:0]          stg_n;
  logic [8*MAX_BYTES-1:0] stg_data;
  logic [NW-1:0]          push_n;
  logic                   accept;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic [7:0]             fifo_rd_data;
  logic                   pop;
  logic [UW-1:0]          used;

  assign push_n    = stg_valid ? stg_n : '0;
  assign used      = UW'(fifo_count) + UW'(push_n);
  assign key_ready = (used + UW'(MAX_BYTES)) <= UW'(FIFO_DEPTH);
  assign accept    = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_n     <= '0;
      stg_data  <= '0;
    end else begin
      stg_valid <= accept;
      if (accept) begin
        stg_n    <= evt_n;
        stg_data <= evt_data;
      end
    end
  end

  ps2_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WR_MAX (MAX_BYTES)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_n    (push_n),
    .wr_data (stg_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  ps2_state_e                state, state_d;
  logic [DIV_W-1:0]          div_cnt, cnt_d;
  logic [3:0]                bit_idx, idx_d;
  logic [PS2_FRAME_BITS-2:0] shreg, sh_d;
  logic                      clk_q, clk_d;
  logic                      data_q, data_d;
  logic                      busy_q, busy_d;
  logic [PS2_FRAME_BITS-1:0] frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= cnt_d;
      bit_idx <= idx_d;
      shreg   <= sh_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Data only changes on the LO->HI step, so it is stable at every clock fall.
  always_comb begin
    state_d = state;
    cnt_d   = div_cnt;
    idx_d   = bit_idx;
    sh_d    = shreg;
    clk_d   = clk_q;
    data_d  = data_q;
    pop     = 1'b0;
    frame   = ps2_frame(fifo_rd_data);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = frame[0];
          sh_d    = frame[PS2_FRAME_BITS-1:1];
          idx_d   = '0;
          cnt_d   = HALF_LD;
          state_d = HI;
        end
      end
      HI: begin
        if (div_cnt == '0) begin
          clk_d   = 1'b0;
          cnt_d   = HALF_LD;
          state_d = LO;
        end else begin
          cnt_d = div_cnt - DIV_W'(1);
        end
      end
      LO: begin
        if (div_cnt == '0) begin
          clk_d = 1'b1;
          if (bit_idx == LAST_IDX) begin
            data_d  = 1'b1;
            cnt_d   = GAP_LD;
            state_d = GAP;
          end else begin
            idx_d   = bit_idx + 4'd1;
            data_d  = shreg[0];
            sh_d    = {1'b0, shreg[PS2_FRAME_BITS-2:1]};
            cnt_d   = HALF_LD;
            state_d = HI;
          end
        end else begin
          cnt_d = div_cnt - DIV_W'(1);
        end
      end
      GAP: begin
        if (div_cnt == '0) state_d = IDLE;
        else               cnt_d   = div_cnt - DIV_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) ||
             (CW'(fifo_count + CW'(push_n) - CW'(pop)) != '0);
  end

  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign busy     = busy_q;

endmodule
